// File: rtl/tile_pkg.sv
// Shared types for the lane tile renderer: FSM states, LOAD actions, colours.
package tile_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ERASE = 3'd2,
    S_DRAW  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // What the current lane visit will paint, decided once in LOAD.
  typedef enum logic [1:0] {
    A_SKIP       = 2'd0,  // nothing to paint
    A_ERASE_ONLY = 2'd1,  // erase old tile, lane goes inactive
    A_MOVE       = 2'd2,  // erase old tile, then draw at new y
    A_SPAWN      = 2'd3   // draw new tile at y=0
  } action_e;

  localparam logic [2:0] BG_COLOUR = 3'b000;

endpackage

// File: rtl/tile_pixel_counter.sv
// Row-major pixel scanner over one tile: cx inner, cy outer, wraps after last.
module tile_pixel_counter #(
  parameter int TILE_W = 32,
  parameter int TILE_H = 16,
  localparam int CXW = (TILE_W > 1) ? $clog2(TILE_W) : 1,
  localparam int CYW = (TILE_H > 1) ? $clog2(TILE_H) : 1
) (
  input  logic           clock,
  input  logic           clear_b,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [CXW-1:0] cx_o,
  output logic [CYW-1:0] cy_o,
  output logic           last_o
);

  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic           x_end, y_end;

  assign x_end  = (cx_q == CXW'(TILE_W - 1));
  assign y_end  = (cy_q == CYW'(TILE_H - 1));
  assign last_o = x_end && y_end;
  assign cx_o   = cx_q;
  assign cy_o   = cy_q;

  // Next position: clear wins, otherwise step through the tile when enabled.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      if (x_end) begin
        cx_d = '0;
        cy_d = y_end ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/lane_tile_renderer.sv
// Multi-lane falling-tile engine: per frame, visits each lane, erases/moves/
// spawns its tile one pixel per cycle, and keeps hit/miss scores.
module lane_tile_renderer
  import tile_pkg::*;
#(
  parameter int         LANES       = 4,
  parameter int         TILE_W      = 32,
  parameter int         TILE_H      = 16,
  parameter int         LANE_X0     = 8,
  parameter int         LANE_PITCH  = 36,
  parameter int         SCREEN_H    = 120,
  parameter int         STEP        = 4,
  parameter int         HIT_Y       = 96,
  parameter logic [2:0] TILE_COLOUR = 3'b111,
  parameter int         SCORE_W     = 8
) (
  input  logic               clock,
  input  logic               clear_b,
  input  logic               go,
  input  logic [LANES-1:0]   spawn,
  input  logic [LANES-1:0]   hit,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               plot,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses
);

  localparam int LI_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CXW  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int CYW  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int SW1  = SCORE_W + 1;

  state_e                  state_q, state_d;
  action_e                 act_q, act_d;
  logic [LI_W-1:0]         li_q, li_d;
  logic [6:0]              base_q, base_d;     // y of the rectangle being painted
  logic [LANES-1:0]        active_q, active_d;
  logic [LANES-1:0][6:0]   tile_y_q, tile_y_d;
  logic [LANES-1:0]        hit_pq, hit_pd;
  logic [LANES-1:0]        spawn_pq, spawn_pd;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [SCORE_W-1:0]      misses_q, misses_d;
  logic [SW1-1:0]          msum;
  logic [1:0]              miss_inc;
  logic                    score_inc;
  logic                    clr_lane;

  logic                    cnt_clr, cnt_en, cnt_last;
  logic [CXW-1:0]          cx;
  logic [CYW-1:0]          cy;

  logic [7:0]              x_q;
  logic [6:0]              y_q;
  logic [2:0]              colour_q;
  logic                    plot_q, busy_q, done_q;

  // Current-lane view used by LOAD.
  logic [6:0]              cur_y;
  logic [7:0]              ny;
  logic                    in_win, ovf, painting;
  logic [7:0]              x_base;

  assign cur_y    = tile_y_q[li_q];
  assign ny       = 8'(cur_y) + 8'(STEP);
  assign ovf      = ny > 8'(SCREEN_H - TILE_H);
  assign in_win   = (int'(cur_y) + TILE_H) > HIT_Y;
  assign painting = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign x_base   = 8'(LANE_X0 + int'(li_q) * LANE_PITCH);

  tile_pixel_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_cnt (
    .clock   (clock),
    .clear_b (clear_b),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cx_o    (cx),
    .cy_o    (cy),
    .last_o  (cnt_last)
  );

  // FSM next state, lane decisions made in LOAD, and scan sequencing.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    li_d      = li_q;
    base_d    = base_q;
    active_d  = active_q;
    tile_y_d  = tile_y_q;
    miss_inc  = 2'd0;
    score_inc = 1'b0;
    clr_lane  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          li_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        clr_lane = 1'b1;
        cnt_clr  = 1'b1;
        base_d   = cur_y;
        if (active_q[li_q]) begin
          if (hit_pq[li_q] && in_win) begin
            act_d            = A_ERASE_ONLY;
            active_d[li_q]   = 1'b0;
            score_inc        = 1'b1;
          end else begin
            if (hit_pq[li_q]) miss_inc = miss_inc + 2'd1;
            if (ovf) begin
              act_d          = A_ERASE_ONLY;
              active_d[li_q] = 1'b0;
              miss_inc       = miss_inc + 2'd1;
            end else begin
              act_d          = A_MOVE;
              tile_y_d[li_q] = ny[6:0];
            end
          end
        end else begin
          // A stray key on an empty lane is a miss; spawn is still honoured.
          if (hit_pq[li_q]) miss_inc = 2'd1;
          if (spawn_pq[li_q]) begin
            act_d          = A_SPAWN;
            active_d[li_q] = 1'b1;
            tile_y_d[li_q] = '0;
            base_d         = '0;
          end else begin
            act_d = A_SKIP;
          end
        end
        case (act_d)
          A_SKIP:  state_d = S_NEXT;
          A_SPAWN: state_d = S_DRAW;
          default: state_d = S_ERASE;
        endcase
      end
      S_ERASE: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          if (act_q == A_MOVE) begin
            state_d = S_DRAW;
            base_d  = tile_y_q[li_q];  // already advanced in LOAD
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_DRAW: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (li_q == LI_W'(LANES - 1)) begin
          state_d = S_DONE;
        end else begin
          li_d    = li_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky request capture; LOAD consumes the current lane's bits but a
  // request arriving in that same cycle survives.
  always_comb begin
    hit_pd   = hit_pq | hit;
    spawn_pd = spawn_pq | spawn;
    if (clr_lane) begin
      hit_pd[li_q]   = hit[li_q];
      spawn_pd[li_q] = spawn[li_q];
    end
  end

  // Saturating score and miss counters.
  always_comb begin
    score_d = score_q;
    if (score_inc && (score_q != '1)) score_d = score_q + 1'b1;
    msum     = {1'b0, misses_q} + SW1'(miss_inc);
    misses_d = msum[SCORE_W] ? '1 : msum[SCORE_W-1:0];
  end

  // Control, lane and counter state.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state_q  <= S_IDLE;
      act_q    <= A_SKIP;
      li_q     <= '0;
      base_q   <= '0;
      active_q <= '0;
      tile_y_q <= '0;
      hit_pq   <= '0;
      spawn_pq <= '0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      li_q     <= li_d;
      base_q   <= base_d;
      active_q <= active_d;
      tile_y_q <= tile_y_d;
      hit_pq   <= hit_pd;
      spawn_pq <= spawn_pd;
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  // Registered pixel port and status; pixel fields hold between plots.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BG_COLOUR;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      plot_q <= painting;
      busy_q <= (state_q != S_IDLE) && (state_q != S_DONE);
      done_q <= (state_q == S_DONE);
      if (painting) begin
        x_q      <= x_base + 8'(cx);
        y_q      <= base_q + 7'(cy);
        colour_q <= (state_q == S_DRAW) ? TILE_COLOUR : BG_COLOUR;
      end
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign score  = score_q;
  assign misses = misses_q;

endmodule

// File: tb/tb_lane_tile_renderer.sv
// Self-checking bench: directed frame table, reset abort, then random frames
// against a lane-level reference model.
module tb_lane_tile_renderer;

  localparam int LANES = 4, TW = 4, TH = 2, SH = 10, STP = 4, HY = 6;
  localparam int X0 = 0, PITCH = 5;

  logic       clock = 1'b0;
  logic       clear_b = 1'b0;
  logic       go = 1'b0;
  logic [3:0] spawn = '0, hit = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
  logic [7:0] score, misses;

  lane_tile_renderer #(
    .LANES(LANES), .TILE_W(TW), .TILE_H(TH), .LANE_X0(X0), .LANE_PITCH(PITCH),
    .SCREEN_H(SH), .STEP(STP), .HIT_Y(HY), .TILE_COLOUR(3'b111), .SCORE_W(8)
  ) dut (
    .clock(clock), .clear_b(clear_b), .go(go), .spawn(spawn), .hit(hit),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
    .score(score), .misses(misses)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_act[LANES], m_y[LANES], m_score, m_miss;
  logic [17:0] exp_q[$], got_q[$];

  function automatic void m_reset();
    for (int l = 0; l < LANES; l++) begin m_act[l] = 0; m_y[l] = 0; end
    m_score = 0; m_miss = 0;
  endfunction

  function automatic void rect(int l, int yy, int c);
    for (int r = 0; r < TH; r++)
      for (int k = 0; k < TW; k++)
        exp_q.push_back({8'(X0 + l*PITCH + k), 7'(yy + r), 3'(c)});
  endfunction

  function automatic void miss1();
    if (m_miss < 255) m_miss++;
  endfunction

  function automatic void m_frame(logic [3:0] sp, logic [3:0] hp);
    exp_q.delete();
    for (int l = 0; l < LANES; l++) begin
      if (m_act[l] != 0) begin
        if (hp[l] && (m_y[l] + TH > HY)) begin
          rect(l, m_y[l], 0); m_act[l] = 0;
          if (m_score < 255) m_score++;
        end else begin
          if (hp[l]) miss1();
          rect(l, m_y[l], 0);
          if (m_y[l] + STP > SH - TH) begin m_act[l] = 0; miss1(); end
          else begin m_y[l] += STP; rect(l, m_y[l], 7); end
        end
      end else begin
        if (hp[l]) miss1();
        if (sp[l]) begin m_act[l] = 1; m_y[l] = 0; rect(l, 0, 7); end
      end
    end
  endfunction

  // ---------------- DUT frame driver ----------------
  int lat;

  task automatic dut_frame(input logic [3:0] sp, input logic [3:0] hp);
    @(negedge clock); go = 1'b1; spawn = sp; hit = hp;
    @(posedge clock); #1; go = 1'b0; spawn = '0; hit = '0;
    got_q.delete(); lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clock); #1;
      if (n == 1) chk("busy_start", busy, 1);
      if (plot) got_q.push_back({x, y, colour});
      if (done) begin
        lat = n;
        chk("busy_at_done", busy, 0);
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic cmp_pixels(input string name);
    int bad = 0;
    if (got_q.size() != exp_q.size()) bad = 1;
    else
      for (int i = 0; i < got_q.size(); i++)
        if (got_q[i] != exp_q[i]) begin
          if (bad == 0)
            $display("FAIL %s pixel %0d: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                     name, i, got_q[i][17:10], got_q[i][9:3], got_q[i][2:0],
                     exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
          bad++;
        end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s pixels: got %0d plots (%0d bad) expected %0d plots",
               name, got_q.size(), bad, exp_q.size());
    end
  endtask

  typedef struct {
    logic [3:0] sp, hp;
    int         nplot, lat, score, miss;
  } vec_t;
  vec_t tbl[12];

  initial begin
    // name: spawn, hit, plots, done latency, score, misses
    tbl[0]  = '{4'b0000, 4'b0000,  0,  9, 0, 0};  // idle frame
    tbl[1]  = '{4'b0100, 4'b0000,  8, 17, 0, 0};  // spawn lane 2
    tbl[2]  = '{4'b0000, 4'b0000, 16, 25, 0, 0};  // 0 -> 4
    tbl[3]  = '{4'b0000, 4'b0000, 16, 25, 0, 0};  // 4 -> 8, fits exactly
    tbl[4]  = '{4'b0000, 4'b0000,  8, 17, 0, 1};  // 8 -> 12 falls off
    tbl[5]  = '{4'b0100, 4'b0000,  8, 17, 0, 1};
    tbl[6]  = '{4'b0000, 4'b0000, 16, 25, 0, 1};
    tbl[7]  = '{4'b0000, 4'b0000, 16, 25, 0, 1};
    tbl[8]  = '{4'b0000, 4'b0110,  8, 17, 1, 2};  // hit lane 2 scores, lane 1 miss
    tbl[9]  = '{4'b0001, 4'b0001,  8, 17, 1, 3};  // miss + spawn on lane 0
    tbl[10] = '{4'b1000, 4'b0000, 24, 33, 1, 3};
    tbl[11] = '{4'b1000, 4'b0000, 32, 41, 1, 3};  // spawn on active lane 3 dropped

    // reset state
    #12;
    chk("rst_plot", plot, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);   chk("rst_x", x, 0);
    chk("rst_y", y, 0);         chk("rst_colour", colour, 0);
    chk("rst_score", score, 0); chk("rst_misses", misses, 0);
    @(negedge clock); clear_b = 1'b1;
    m_reset();

    // directed table
    for (int i = 0; i < 12; i++) begin
      m_frame(tbl[i].sp, tbl[i].hp);
      chk($sformatf("tbl%0d_model_plots", i), exp_q.size(), tbl[i].nplot);
      dut_frame(tbl[i].sp, tbl[i].hp);
      cmp_pixels($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_score", i), score, tbl[i].score);
      chk($sformatf("tbl%0d_misses", i), misses, tbl[i].miss);
      if (i == 1) begin
        if (got_q.size() >= 8) begin
          chk("spawn_first_pix", int'(got_q[0]), int'({8'd10, 7'd0, 3'd7}));
          chk("spawn_last_pix",  int'(got_q[7]), int'({8'd13, 7'd1, 3'd7}));
        end else chk("spawn_pix_count", got_q.size(), 8);
      end
    end

    // reset in the middle of the lane 0 erase
    begin
      int n = 0;
      @(negedge clock); go = 1'b1;
      @(posedge clock); #1; go = 1'b0;
      while (!plot && n < 50) begin @(posedge clock); #1; n++; end
      chk("abort_plot_seen", plot, 1);
      #2; clear_b = 1'b0;
      #1;
      chk("abort_plot", plot, 0);   chk("abort_busy", busy, 0);
      chk("abort_score", score, 0); chk("abort_misses", misses, 0);
      @(posedge clock); #1;
      chk("abort_no_plot", plot, 0);
      @(negedge clock); clear_b = 1'b1;
      m_reset();
      m_frame(4'b0000, 4'b0000);
      dut_frame(4'b0000, 4'b0000);
      cmp_pixels("post_reset");
      chk("post_reset_latency", lat, 9);
    end

    // random frames against the model
    for (int f = 0; f < 30; f++) begin
      logic [3:0] sp, hp;
      sp = 4'($urandom) & 4'($urandom);
      hp = 4'($urandom) & 4'($urandom);
      m_frame(sp, hp);
      dut_frame(sp, hp);
      cmp_pixels($sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_latency", f), lat, 2*LANES + 1 + exp_q.size());
      chk($sformatf("rnd%0d_score", f), score, m_score);
      chk($sformatf("rnd%0d_misses", f), misses, m_miss);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
